// File: rtl/ens0_input_packer.sv
// Double-buffered packer: assembles narrow pixel beats into full layer0 input vectors,
// dropping short frames and truncating long ones, with valid/ready on both sides.
module ens0_input_packer #(
  parameter int PIX_W    = 1,
  parameter int BEAT_PIX = 16,
  parameter int N_PIX    = 784
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [BEAT_PIX*PIX_W-1:0]   s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [N_PIX*PIX_W-1:0]      m_data,
  output logic                        err_short,
  output logic                        err_long,
  output logic                        state_dbg
);
  // Handshake: a beat moves on a clock edge where valid and ready are both high;
  // ready never looks at the opposite side's ready in the same cycle.

  localparam int BEATS  = N_PIX / BEAT_PIX;
  localparam int BEAT_W = BEAT_PIX * PIX_W;
  localparam int VEC_W  = N_PIX * PIX_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((N_PIX % BEAT_PIX) != 0) begin : g_bad_cfg
      $error("ens0_input_packer: N_PIX must be a multiple of BEAT_PIX");
    end
  endgenerate

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       occ_q, occ_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic [VEC_W-1:0] buf0_q, buf1_q;
  logic             in_xfer, out_xfer, commit, wr_en;

  assign s_ready   = (state_q == DRAIN) || (occ_q != 2'd2);
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = rd_sel_q ? buf1_q : buf0_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign state_dbg = state_q;
  assign in_xfer   = s_valid && s_ready;
  assign out_xfer  = m_valid && m_ready;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    wr_sel_d    = wr_sel_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    commit      = 1'b0;
    wr_en       = 1'b0;
    if (state_q == FILL) begin
      if (in_xfer) begin
        wr_en = 1'b1;
        if (beat_cnt_q == LAST_BEAT) begin
          // The vector is complete either way; a missing s_last means the rest is junk.
          commit     = 1'b1;
          wr_sel_d   = ~wr_sel_q;
          beat_cnt_d = '0;
          if (!s_last) begin
            err_long_d = 1'b1;
            state_d    = DRAIN;
          end
        end else if (s_last) begin
          err_short_d = 1'b1;
          beat_cnt_d  = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end else begin
      if (in_xfer && s_last) begin
        state_d    = FILL;
        beat_cnt_d = '0;
      end
    end
  end

  always_comb begin
    occ_d    = occ_q;
    rd_sel_d = rd_sel_q ^ out_xfer;
    case ({commit, out_xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      beat_cnt_q  <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      occ_q       <= 2'd0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      occ_q       <= occ_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  // Only the uncommitted buffer is ever written, so the read side stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_cnt_q == CNT_W'(k)) begin
          if (wr_sel_q) buf1_q[k*BEAT_W +: BEAT_W] <= s_data;
          else          buf0_q[k*BEAT_W +: BEAT_W] <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ens0_input_packer.sv
// Bench for ens0_input_packer: frame driver with a vector scoreboard and per-scenario tasks.
module tb_ens0_input_packer;
  localparam int PIX_W    = 1;
  localparam int BEAT_PIX = 16;
  localparam int N_PIX    = 784;
  localparam int BEATS    = N_PIX / BEAT_PIX;
  localparam int BEAT_W   = BEAT_PIX * PIX_W;
  localparam int VEC_W    = N_PIX * PIX_W;

  logic              clk, rst_n;
  logic              s_valid, s_ready, s_last;
  logic [BEAT_W-1:0] s_data;
  logic              m_valid, m_ready;
  logic [VEC_W-1:0]  m_data;
  logic              err_short, err_long, state_dbg;

  logic [VEC_W-1:0]  exp_q[$];
  int                n_total = 0;
  int                n_bad   = 0;

  ens0_input_packer #(.PIX_W(PIX_W), .BEAT_PIX(BEAT_PIX), .N_PIX(N_PIX)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_short(err_short), .err_long(err_long), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every output transfer is checked against the oldest expected vector
  always @(negedge clk) begin
    #2;
    if (rst_n && m_valid && m_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got m_data=%h, required no output", m_data);
      end else begin
        logic [VEC_W-1:0] exp_v;
        exp_v = exp_q.pop_front();
        if (m_data !== exp_v) begin
          n_bad++;
          $display("FAIL vector_data: got %h required %h", m_data, exp_v);
        end
      end
    end
  end

  // driver: one frame of n_beats; s_last on beat last_idx (-1 for none)
  task automatic send_frame(input int n_beats, input int last_idx,
                            input bit idx_data, input bit ready_on_last);
    logic [VEC_W-1:0]  vec;
    logic [BEAT_W-1:0] d;
    bit in_drain, exp_s, exp_l;
    int n;
    vec = '0;
    in_drain = 1'b0;
    for (int k = 0; k < n_beats; k++) begin
      d = idx_data ? BEAT_W'(k) : BEAT_W'($urandom_range(0, 65535));
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (k == last_idx);
      exp_s = 1'b0;
      exp_l = 1'b0;
      if (!in_drain) begin
        if (k < BEATS) vec[k*BEAT_W +: BEAT_W] = d;
        if (k == BEATS - 1) begin
          exp_q.push_back(vec);
          if (!s_last) begin
            exp_l = 1'b1;
            in_drain = 1'b1;
          end
        end else if (s_last) begin
          exp_s = 1'b1;
        end
      end else if (s_last) begin
        in_drain = 1'b0;
      end
      if (ready_on_last && k == n_beats - 1) m_ready = 1'b1;
      n = 0;
      while (!s_ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) begin
        n_total++;
        n_bad++;
        $display("FAIL s_ready_timeout: beat %0d never accepted, required acceptance", k);
      end
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (err_short !== exp_s) begin
        n_bad++;
        $display("FAIL err_short beat %0d: got %b required %b", k, err_short, exp_s);
      end
      n_total++;
      if (err_long !== exp_l) begin
        n_bad++;
        $display("FAIL err_long beat %0d: got %b required %b", k, err_long, exp_l);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n >= 500) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d vectors still pending, m_valid=%b, required 0", exp_q.size(), m_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    n_total++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    n_total++;
    if (m_data !== '0) begin n_bad++; $display("FAIL reset_m_data: got %h required 0", m_data); end
    n_total++;
    if (err_short !== 1'b0 || err_long !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got short=%b long=%b required 0 0", err_short, err_long);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    m_ready = 1'b1;
    send_frame(BEATS, BEATS - 1, 1'b1, 1'b0);
    n_total++;
    if (m_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: m_valid got %b required 1", m_valid); end
    @(negedge clk);
    n_total++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_after_pop: m_valid got %b required 0", m_valid); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    send_frame(BEATS, BEATS - 1, 1'b0, 1'b0);
    send_frame(BEATS, BEATS - 1, 1'b0, 1'b0);
    fork
      send_frame(BEATS, BEATS - 1, 1'b0, 1'b0);
      begin
        repeat (2) @(negedge clk);
        n_total++;
        if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_s_ready_full: got %b required 0", s_ready); end
        n_total++;
        if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_m_valid_full: got %b required 1", m_valid); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
      end
    join
    m_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_short_frame();
    m_ready = 1'b1;
    send_frame(11, 10, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_total++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL short_no_valid: m_valid got %b required 0", m_valid); end
    send_frame(BEATS, BEATS - 1, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_long_frame();
    m_ready = 1'b1;
    send_frame(BEATS + 3, BEATS + 2, 1'b0, 1'b0);
    wait_drain();
    send_frame(BEATS, BEATS - 1, 1'b1, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    send_frame(BEATS, BEATS - 1, 1'b0, 1'b0);
    send_frame(BEATS, BEATS - 1, 1'b0, 1'b1);
    n_total++;
    if (m_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_no_gap: m_valid got %b required 1", m_valid); end
    @(negedge clk);
    n_total++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_occ_one: m_valid got %b required 0", m_valid); end
    wait_drain();
  endtask

  task automatic test_reset_midframe();
    m_ready = 1'b0;
    send_frame(BEATS, BEATS - 1, 1'b0, 1'b0);
    send_frame(20, -1, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_total++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_m_valid: got %b required 0", m_valid); end
    n_total++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_s_ready: got %b required 1", s_ready); end
    n_total++;
    if (m_data !== '0) begin n_bad++; $display("FAIL midreset_m_data: got %h required 0", m_data); end
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    send_frame(BEATS, BEATS - 1, 1'b0, 1'b0);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_back_to_back();
    test_reset_midframe();
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expected: %0d vectors never output, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
